// File: rtl/bank_cmd_scheduler.sv
// rtl/bank_cmd_scheduler.sv - single-request DRAM bank command scheduler
// Tracks open rows of 16 banks and emits ACT/PRE/RD/WR at the earliest legal cycle.
module bank_cmd_scheduler #(
  parameter int RA_BITS    = 16,
  parameter int CA_BITS    = 10,
  parameter int DATA_BITS  = 16,
  parameter int INDEX_BITS = 7,
  parameter int T_RCD      = 4,
  parameter int T_RP       = 4,
  parameter int T_RAS      = 10,
  parameter int T_CCD      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_type,
  input  logic [RA_BITS-1:0]    req_row,
  input  logic [CA_BITS-1:0]    req_col,
  input  logic [1:0]            req_ba,
  input  logic [1:0]            req_bg,
  input  logic [DATA_BITS-1:0]  req_data,
  input  logic [INDEX_BITS-1:0] req_idx,
  output logic                  cmd_valid,
  output logic [1:0]            cmd_type,
  output logic [1:0]            cmd_ba,
  output logic [1:0]            cmd_bg,
  output logic [RA_BITS-1:0]    cmd_row,
  output logic [CA_BITS-1:0]    cmd_col,
  output logic [DATA_BITS-1:0]  cmd_data,
  output logic [INDEX_BITS-1:0] cmd_idx
);

  localparam int CW = $clog2(T_RAS + T_RP + T_RCD + T_CCD + 1);

  // ISSUE is the cycle the RD/WR pulse is on the bus; ready returns after it.
  typedef enum logic [2:0] {IDLE, CHECK, PRE, WAIT_RP, WAIT_RCD, ISSUE} state_t;

  state_t                  state;
  logic                    r_type;
  logic [RA_BITS-1:0]      r_row;
  logic [CA_BITS-1:0]      r_col;
  logic [3:0]              r_bank;
  logic [DATA_BITS-1:0]    r_data;
  logic [INDEX_BITS-1:0]   r_idx;
  logic [15:0]             open_valid;
  logic [RA_BITS-1:0]      open_row [16];
  logic [CW-1:0]           ras_cnt [16];
  logic [CW-1:0]           ccd_cnt;
  logic [CW-1:0]           wait_cnt;
  logic                    hit, ras_ok, ccd_ok, wait_zero;
  logic                    do_act, do_pre, do_rw;

  // Commands are decided one cycle ahead and appear on the registered bus next cycle.
  always_comb begin
    hit       = open_valid[r_bank] && (open_row[r_bank] == r_row);
    ras_ok    = (ras_cnt[r_bank] == '0);
    ccd_ok    = (ccd_cnt == '0);
    wait_zero = (wait_cnt == '0);
    do_rw     = ((state == CHECK && hit) || (state == WAIT_RCD && wait_zero)) && ccd_ok;
    do_act    = (state == CHECK && !open_valid[r_bank]) || (state == WAIT_RP && wait_zero);
    do_pre    = ((state == CHECK && open_valid[r_bank] && !hit) || state == PRE) && ras_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      cmd_valid  <= 1'b0;
      cmd_type   <= '0;
      cmd_ba     <= '0;
      cmd_bg     <= '0;
      cmd_row    <= '0;
      cmd_col    <= '0;
      cmd_data   <= '0;
      cmd_idx    <= '0;
      r_type     <= 1'b0;
      r_row      <= '0;
      r_col      <= '0;
      r_bank     <= '0;
      r_data     <= '0;
      r_idx      <= '0;
      open_valid <= '0;
      ccd_cnt    <= '0;
      wait_cnt   <= '0;
      for (int i = 0; i < 16; i++) begin
        open_row[i] <= '0;
        ras_cnt[i]  <= '0;
      end
    end else begin
      cmd_valid <= 1'b0;
      cmd_type  <= '0;
      cmd_ba    <= '0;
      cmd_bg    <= '0;
      cmd_row   <= '0;
      cmd_col   <= '0;
      cmd_data  <= '0;
      cmd_idx   <= '0;
      if (!ccd_ok) ccd_cnt <= ccd_cnt - 1'b1;
      for (int i = 0; i < 16; i++) begin
        if (ras_cnt[i] != '0) ras_cnt[i] <= ras_cnt[i] - 1'b1;
      end

      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            r_type    <= req_type;
            r_row     <= req_row;
            r_col     <= req_col;
            r_bank    <= {req_bg, req_ba};
            r_data    <= req_data;
            r_idx     <= req_idx;
            req_ready <= 1'b0;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (hit) begin
            state    <= WAIT_RCD;
            wait_cnt <= '0;
          end else if (open_valid[r_bank]) begin
            state <= PRE;
          end
        end
        WAIT_RP, WAIT_RCD: begin
          if (!wait_zero) wait_cnt <= wait_cnt - 1'b1;
        end
        ISSUE: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: ;
      endcase

      if (do_act) begin
        cmd_valid          <= 1'b1;
        cmd_type           <= 2'b00;
        cmd_ba             <= r_bank[1:0];
        cmd_bg             <= r_bank[3:2];
        cmd_row            <= r_row;
        open_valid[r_bank] <= 1'b1;
        open_row[r_bank]   <= r_row;
        ras_cnt[r_bank]    <= CW'(T_RAS - 1);
        wait_cnt           <= CW'(T_RCD - 1);
        state              <= WAIT_RCD;
      end
      if (do_pre) begin
        cmd_valid          <= 1'b1;
        cmd_type           <= 2'b11;
        cmd_ba             <= r_bank[1:0];
        cmd_bg             <= r_bank[3:2];
        open_valid[r_bank] <= 1'b0;
        wait_cnt           <= CW'(T_RP - 1);
        state              <= WAIT_RP;
      end
      if (do_rw) begin
        cmd_valid <= 1'b1;
        cmd_type  <= r_type ? 2'b10 : 2'b01;
        cmd_ba    <= r_bank[1:0];
        cmd_bg    <= r_bank[3:2];
        cmd_col   <= r_col;
        cmd_data  <= r_type ? r_data : '0;
        cmd_idx   <= r_idx;
        ccd_cnt   <= CW'(T_CCD - 1);
        state     <= ISSUE;
      end
    end
  end

endmodule

// File: tb/tb_bank_cmd_scheduler.sv
// tb/tb_bank_cmd_scheduler.sv - scoreboard bench for bank_cmd_scheduler
module tb_bank_cmd_scheduler;

  localparam int T_RCD = 4;
  localparam int T_RP  = 4;
  localparam int T_RAS = 10;
  localparam int T_CCD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_type = 1'b0;
  logic [15:0] req_row = '0;
  logic [9:0]  req_col = '0;
  logic [1:0]  req_ba = '0;
  logic [1:0]  req_bg = '0;
  logic [15:0] req_data = '0;
  logic [6:0]  req_idx = '0;
  logic        cmd_valid;
  logic [1:0]  cmd_type;
  logic [1:0]  cmd_ba;
  logic [1:0]  cmd_bg;
  logic [15:0] cmd_row;
  logic [9:0]  cmd_col;
  logic [15:0] cmd_data;
  logic [6:0]  cmd_idx;

  bank_cmd_scheduler dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
    .req_row(req_row), .req_col(req_col), .req_ba(req_ba), .req_bg(req_bg),
    .req_data(req_data), .req_idx(req_idx),
    .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_ba(cmd_ba), .cmd_bg(cmd_bg),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_data(cmd_data), .cmd_idx(cmd_idx)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    longint      at;
    logic [1:0]  typ;
    logic [1:0]  ba;
    logic [1:0]  bg;
    logic [15:0] row;
    logic [9:0]  col;
    logic [15:0] data;
    logic [6:0]  idx;
  } exp_t;

  exp_t q[$];

  // Reference model: absolute cycle bookkeeping per bank.
  bit          mo_open [16];
  logic [15:0] mo_row  [16];
  longint      mo_act  [16];
  longint      mo_rw;
  longint      mo_ready;

  function automatic longint maxl(input longint a, input longint b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mo_open[i] = 1'b0;
      mo_row[i]  = '0;
      mo_act[i]  = -1000;
    end
    mo_rw    = -1000;
    mo_ready = 0;
    q.delete();
  endtask

  task automatic push(input longint at, input logic [1:0] typ, input logic [1:0] ba,
                      input logic [1:0] bg, input logic [15:0] row, input logic [9:0] col,
                      input logic [15:0] data, input logic [6:0] idx);
    exp_t e;
    e.at = at; e.typ = typ; e.ba = ba; e.bg = bg;
    e.row = row; e.col = col; e.data = data; e.idx = idx;
    q.push_back(e);
  endtask

  task automatic predict(input longint k, input bit typ, input logic [15:0] row,
                         input logic [9:0] col, input logic [1:0] ba, input logic [1:0] bg,
                         input logic [15:0] data, input logic [6:0] idx);
    int     b;
    longint t_pre, t_act, t_rw;
    b = {bg, ba};
    if (mo_open[b] && mo_row[b] == row) begin
      t_rw = maxl(k + 2, mo_rw + T_CCD);
    end else begin
      if (mo_open[b]) begin
        t_pre = maxl(k + 2, mo_act[b] + T_RAS);
        push(t_pre, 2'b11, ba, bg, 16'h0, 10'h0, 16'h0, 7'h0);
        t_act = t_pre + T_RP;
      end else begin
        t_act = k + 2;
      end
      push(t_act, 2'b00, ba, bg, row, 10'h0, 16'h0, 7'h0);
      mo_act[b]  = t_act;
      mo_open[b] = 1'b1;
      mo_row[b]  = row;
      t_rw = maxl(t_act + T_RCD, mo_rw + T_CCD);
    end
    push(t_rw, typ ? 2'b10 : 2'b01, ba, bg, 16'h0, col, typ ? data : 16'h0, idx);
    mo_rw    = t_rw;
    mo_ready = t_rw + 1;
  endtask

  exp_t e;
  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_cmd cyc=%0d type=%0d bg=%0d ba=%0d", cyc, cmd_type, cmd_bg, cmd_ba);
        end else begin
          e = q.pop_front();
          if (cyc != e.at) begin
            fails++;
            $display("FAIL cmd_cycle type=%0d got cyc=%0d expected cyc=%0d", e.typ, cyc, e.at);
          end
          tests++;
          if ({cmd_type, cmd_bg, cmd_ba, cmd_row, cmd_col, cmd_data, cmd_idx} !=
              {e.typ, e.bg, e.ba, e.row, e.col, e.data, e.idx}) begin
            fails++;
            $display("FAIL cmd_fields got t=%0d bg=%0d ba=%0d row=%h col=%h data=%h idx=%h expected t=%0d bg=%0d ba=%0d row=%h col=%h data=%h idx=%h",
                     cmd_type, cmd_bg, cmd_ba, cmd_row, cmd_col, cmd_data, cmd_idx,
                     e.typ, e.bg, e.ba, e.row, e.col, e.data, e.idx);
          end
        end
      end else begin
        tests++;
        if ({cmd_type, cmd_bg, cmd_ba, cmd_row, cmd_col, cmd_data, cmd_idx} != '0) begin
          fails++;
          $display("FAIL idle_zero cyc=%0d got fields nonzero expected 0", cyc);
        end
      end
    end
  end

  task automatic check_reset_state(input string name);
    tests++;
    if (!req_ready || cmd_valid ||
        {cmd_type, cmd_bg, cmd_ba, cmd_row, cmd_col, cmd_data, cmd_idx} != '0) begin
      fails++;
      $display("FAIL %s got ready=%0b valid=%0b type=%0d row=%h expected ready=1 valid=0 fields=0",
               name, req_ready, cmd_valid, cmd_type, cmd_row);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_state("reset_state");
  endtask

  task automatic send(input bit typ, input logic [15:0] row, input logic [9:0] col,
                      input logic [1:0] ba, input logic [1:0] bg, input logic [15:0] data,
                      input logic [6:0] idx, input int gap);
    longint raised;
    int     n;
    @(negedge clk);
    repeat (gap) @(negedge clk);
    req_valid = 1'b1; req_type = typ; req_row = row; req_col = col;
    req_ba = ba; req_bg = bg; req_data = data; req_idx = idx;
    raised = cyc;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!req_ready) begin
      fails++;
      $display("FAIL accept_timeout got ready=0 expected ready=1 within 100 cycles");
      req_valid = 1'b0;
      return;
    end
    if (cyc != maxl(raised, mo_ready)) begin
      fails++;
      $display("FAIL accept_cycle got %0d expected %0d", cyc, maxl(raised, mo_ready));
    end
    predict(cyc, typ, row, col, ba, bg, data, idx);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending expected 0", q.size());
    end
  endtask

  initial begin
    longint t_act;
    model_reset();
    do_reset();

    // empty then hit on bank 5
    send(1'b0, 16'h0010, 10'h003, 2'd1, 2'd1, 16'h0000, 7'd5, 0);
    send(1'b0, 16'h0010, 10'h004, 2'd1, 2'd1, 16'h0000, 7'd6, 0);
    drain();

    // miss held off by tRAS
    do_reset();
    send(1'b0, 16'h0010, 10'h001, 2'd1, 2'd1, 16'h0000, 7'd1, 0);
    send(1'b1, 16'h0020, 10'h002, 2'd1, 2'd1, 16'hBEEF, 7'd2, 0);
    drain();

    // back-to-back hits to two different open banks
    send(1'b0, 16'h0030, 10'h005, 2'd2, 2'd0, 16'h0000, 7'd3, 0);
    send(1'b1, 16'h0020, 10'h006, 2'd1, 2'd1, 16'h1234, 7'd4, 0);
    send(1'b0, 16'h0030, 10'h007, 2'd2, 2'd0, 16'h0000, 7'd8, 0);
    drain();

    // reset while ACT is on the bus; bank must come back closed
    send(1'b0, 16'h0033, 10'h009, 2'd3, 2'd2, 16'h0000, 7'd9, 0);
    t_act = mo_act[{2'd2, 2'd3}];
    while (cyc < t_act) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_state("async_reset");
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    send(1'b0, 16'h0033, 10'h00A, 2'd3, 2'd2, 16'h0000, 7'd10, 0);
    drain();

    for (int i = 0; i < 80; i++) begin
      logic [15:0] row;
      row = 16'h0010 * 16'($urandom_range(1, 3));
      send(1'($urandom_range(0, 1)), row, 10'($urandom), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 1)), 16'($urandom), 7'($urandom), $urandom_range(0, 3));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
